// File: rtl/msx_slot_pkg.sv
// Shared constants and types for the MSX2 slot expander: bus decode addresses,
// mapper reset values and the M1 wait-state FSM encoding.
package msx_slot_pkg;

  localparam logic [15:0] SUBSLOT_ADDR     = 16'hFFFF;
  localparam logic [7:0]  MAPPER_PORT_BASE = 8'hFC;

  // Index 0 is port FC: segments come up as 3,2,1,0 so page n maps segment 3-n.
  localparam logic [3:0][7:0] MAPPER_RST = {8'd0, 8'd1, 8'd2, 8'd3};

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_WAIT = 2'd1,
    W_HOLD = 2'd2
  } wait_state_e;

endpackage

// File: rtl/msx_m1_wait.sv
// M1 wait-state generator: inserts M1_WAITS CPU clocks of WAIT once per opcode fetch.
module msx_m1_wait
  import msx_slot_pkg::*;
#(
  parameter int M1_WAITS = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clk_en,
  input  logic m1_n,
  input  logic mreq_n,
  input  logic rfrsh_n,
  output logic wait_n
);

  generate
    if (M1_WAITS == 0) begin : g_off
      assign wait_n = 1'b1;
    end else begin : g_on
      localparam int CW = $clog2(M1_WAITS + 1);

      wait_state_e   state, state_d;
      logic [CW-1:0] cnt, cnt_d;
      logic          wait_n_d;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          state  <= W_IDLE;
          cnt    <= '0;
          wait_n <= 1'b1;
        end else begin
          state  <= state_d;
          cnt    <= cnt_d;
          wait_n <= wait_n_d;
        end
      end

      always_comb begin
        state_d = state;
        cnt_d   = cnt;
        if (clk_en) begin
          case (state)
            W_IDLE: if (!m1_n && !mreq_n && rfrsh_n) begin
              state_d = W_WAIT;
              cnt_d   = CW'(M1_WAITS);
            end
            W_WAIT: begin
              cnt_d = cnt - 1'b1;
              if (cnt == CW'(1)) state_d = W_HOLD;
            end
            // HOLD keeps one insertion per fetch until M1 is released
            W_HOLD: if (m1_n) state_d = W_IDLE;
            default: state_d = W_IDLE;
          endcase
        end
      end

      always_comb wait_n_d = (state_d != W_WAIT);
    end
  endgenerate

endmodule

// File: rtl/msx_slot_expander.sv
// MSX2 slot decoder: primary slots per page, subslot registers at FFFF for
// expanded primaries, memory-mapper segment registers at I/O FC-FF, M1 waits.
module msx_slot_expander
  import msx_slot_pkg::*;
#(
  parameter logic [3:0] EXPANDED = 4'b1000,
  parameter int         SEG_BITS = 3,
  parameter int         M1_WAITS = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clk_en,
  input  logic [15:0]           addr,
  input  logic [7:0]            d_from_cpu,
  input  logic                  mreq_n,
  input  logic                  iorq_n,
  input  logic                  m1_n,
  input  logic                  rd_n,
  input  logic                  wr_n,
  input  logic                  rfrsh_n,
  input  logic [7:0]            prim_slot,
  output logic [3:0]            sltsl_n,
  output logic [1:0]            sub_sel,
  output logic [14+SEG_BITS-1:0] ram_addr,
  output logic [7:0]            d_to_cpu,
  output logic                  d_oe,
  output logic                  wait_n
);

  logic [1:0] page, ps, top_ps;
  logic       sub_hit, map_hit, commit, committed;

  logic [3:0][7:0]          subreg;
  logic [3:0][SEG_BITS-1:0] seg;

  assign page   = addr[15:14];
  assign ps     = prim_slot[{page, 1'b0} +: 2];
  assign top_ps = prim_slot[7:6];

  assign sub_hit = !mreq_n && (addr == SUBSLOT_ADDR) && EXPANDED[top_ps];
  assign map_hit = !iorq_n && m1_n && (addr[7:2] == MAPPER_PORT_BASE[7:2]);

  // One commit per write strobe: the flag holds off further clk_en edges until wr_n rises
  assign commit = clk_en && !wr_n && rfrsh_n && !committed;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         committed <= 1'b0;
    else if (wr_n)                        committed <= 1'b0;
    else if (commit && (sub_hit || map_hit)) committed <= 1'b1;
  end

  // Non-expanded entries are never written (sub_hit excludes them) and stay 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              subreg <= '0;
    else if (commit && sub_hit) subreg[top_ps] <= d_from_cpu;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) seg[i] <= MAPPER_RST[i][SEG_BITS-1:0];
    end else if (commit && map_hit) begin
      seg[addr[1:0]] <= d_from_cpu[SEG_BITS-1:0];
    end
  end

  always_comb begin
    sltsl_n = 4'hF;
    if (!mreq_n && rfrsh_n && !sub_hit) sltsl_n[ps] = 1'b0;
  end

  assign sub_sel  = EXPANDED[ps] ? subreg[ps][{page, 1'b0} +: 2] : 2'b00;
  assign ram_addr = {seg[page], addr[13:0]};

  always_comb begin
    d_oe     = 1'b0;
    d_to_cpu = 8'hFF;
    if (!rd_n && sub_hit) begin
      d_oe     = 1'b1;
      d_to_cpu = ~subreg[top_ps];
    end else if (!rd_n && map_hit) begin
      d_oe                    = 1'b1;
      d_to_cpu[SEG_BITS-1:0]  = seg[addr[1:0]];
    end
  end

  msx_m1_wait #(.M1_WAITS(M1_WAITS)) u_wait (
    .clk     (clk),
    .reset_n (reset_n),
    .clk_en  (clk_en),
    .m1_n    (m1_n),
    .mreq_n  (mreq_n),
    .rfrsh_n (rfrsh_n),
    .wait_n  (wait_n)
  );

endmodule
